// File: rtl/seg_scan_driver_pkg.sv
// Shared types, constants and the hex glyph table for the seven-segment scan driver.
package seg_scan_driver_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned PHASES     = 4;

  // Segment byte layout is {a,b,c,d,e,f,g,dp}, active-high.
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_t;

  typedef struct packed {
    logic [NUM_DIGITS*4-1:0] digits;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blink;
  } frame_t;

  // Display starts dark until the first frame is loaded.
  localparam frame_t FRAME_RESET = '{digits: '0, blank: '1, dp: '0, blink: '0};

  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    logic [7:0] g;
    g = SEG_BLANK;
    case (v)
      4'h0: g = 8'hFC;
      4'h1: g = 8'h60;
      4'h2: g = 8'hDA;
      4'h3: g = 8'hF2;
      4'h4: g = 8'h66;
      4'h5: g = 8'hB6;
      4'h6: g = 8'hBE;
      4'h7: g = 8'hE0;
      4'h8: g = 8'hFE;
      4'h9: g = 8'hF6;
      4'hA: g = 8'hEE;
      4'hB: g = 8'h3E;
      4'hC: g = 8'h9C;
      4'hD: g = 8'h7A;
      4'hE: g = 8'h9E;
      4'hF: g = 8'h8E;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Frame input and display output bundle between the display-select logic and the scan driver.
interface seg_scan_driver_if import seg_scan_driver_pkg::*; ();

  logic                    enable;
  logic [NUM_DIGITS*4-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blink_in;
  logic                    load;
  logic [7:0]              seg1;
  logic [7:0]              seg2;
  logic [NUM_DIGITS-1:0]   sel;
  logic                    frame_done;

  modport master (
    output enable, digits_in, blank_in, dp_in, blink_in, load,
    input  seg1, seg2, sel, frame_done
  );

  modport slave (
    input  enable, digits_in, blank_in, dp_in, blink_in, load,
    output seg1, seg2, sel, frame_done
  );

endinterface

// File: rtl/seg_scan_driver_tick_divider.sv
// Free-running divider: counts 0..DIV-1 and flags the terminal count for one clock.
module tick_divider #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  // Wrap at the terminal count so the tick period is exactly DIV clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment driver with double-buffered frames and inter-digit dead time.
module seg_scan_driver import seg_scan_driver_pkg::*; #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic                clk,
  input  logic                reset,
  seg_scan_driver_if.slave    bus
);

  logic   scan_tick;
  logic   blink_tick;
  phase_t phase;
  phase_t phase_next;
  logic   boundary;
  logic   blink_phase;
  frame_t pend_frame;
  frame_t act_frame;
  logic   pend_valid;
  logic   armed;
  logic [2:0] hi_idx;
  logic [2:0] lo_idx;
  logic   hi_dark;
  logic   lo_dark;
  logic   show;
  logic [7:0] seg1_next;
  logic [7:0] seg2_next;
  logic [NUM_DIGITS-1:0] sel_next;

  tick_divider #(.DIV(CLK_HZ / SCAN_HZ)) u_scan_div (
    .clk   (clk),
    .reset (reset),
    .tick  (scan_tick)
  );

  tick_divider #(.DIV(CLK_HZ / (2 * BLINK_HZ))) u_blink_div (
    .clk   (clk),
    .reset (reset),
    .tick  (blink_tick)
  );

  // Phase register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase <= PH0;
    else       phase <= phase_next;
  end

  // Phase advance on each scan tick; wrapping out of the last phase marks a frame boundary.
  always_comb begin
    phase_next = phase;
    boundary   = 1'b0;
    if (scan_tick) begin
      unique case (phase)
        PH0: phase_next = PH1;
        PH1: phase_next = PH2;
        PH2: phase_next = PH3;
        PH3: begin
          phase_next = PH0;
          boundary   = 1'b1;
        end
      endcase
    end
  end

  // Blink phase toggles every half-period, independent of the scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           blink_phase <= 1'b0;
    else if (blink_tick) blink_phase <= ~blink_phase;
  end

  // Double buffer: promotion at the boundary uses the old pending frame, so a load
  // landing on the boundary itself stays pending for one more frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_frame <= FRAME_RESET;
      act_frame  <= FRAME_RESET;
      pend_valid <= 1'b0;
    end else begin
      if (boundary && pend_valid) act_frame <= pend_frame;
      if (bus.load) begin
        pend_frame <= '{digits: bus.digits_in, blank: bus.blank_in,
                        dp: bus.dp_in, blink: bus.blink_in};
        pend_valid <= 1'b1;
      end else if (boundary) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // After enable drops, hold the display dark until a scan tick so it resumes on a phase edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           armed <= 1'b0;
    else if (!bus.enable) armed <= 1'b0;
    else if (scan_tick)  armed <= 1'b1;
  end

  // Segment/select values for the current phase; forcing zero on the tick cycle yields the dead time.
  always_comb begin
    hi_idx    = 3'd7 - {1'b0, phase};
    lo_idx    = 3'd3 - {1'b0, phase};
    hi_dark   = act_frame.blank[hi_idx] | (act_frame.blink[hi_idx] & blink_phase);
    lo_dark   = act_frame.blank[lo_idx] | (act_frame.blink[lo_idx] & blink_phase);
    show      = bus.enable && armed && !scan_tick;
    seg1_next = '0;
    seg2_next = '0;
    sel_next  = '0;
    if (show && !hi_dark) begin
      seg1_next        = hex_glyph(act_frame.digits[{hi_idx, 2'b00} +: 4]) | {7'b0, act_frame.dp[hi_idx]};
      sel_next[hi_idx] = 1'b1;
    end
    if (show && !lo_dark) begin
      seg2_next        = hex_glyph(act_frame.digits[{lo_idx, 2'b00} +: 4]) | {7'b0, act_frame.dp[lo_idx]};
      sel_next[lo_idx] = 1'b1;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.seg1       <= '0;
      bus.seg2       <= '0;
      bus.sel        <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.seg1       <= seg1_next;
      bus.seg2       <= seg2_next;
      bus.sel        <= sel_next;
      bus.frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver against a cycle-count based reference model.
module tb_seg_scan_driver;

  localparam int unsigned CLK_HZ    = 1000;
  localparam int unsigned SCAN_HZ   = 100;
  localparam int unsigned BLINK_HZ  = 10;
  localparam int unsigned PHASE_LEN = CLK_HZ / SCAN_HZ;
  localparam int unsigned BLINK_LEN = CLK_HZ / (2 * BLINK_HZ);

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  seg_scan_driver_if bus ();

  seg_scan_driver #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLINK_HZ(BLINK_HZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] glyph_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Reference model: phase, tick and blink follow directly from the cycle count since reset.
  logic [31:0] act_dig, pend_dig;
  logic [7:0]  act_blank, act_dp, act_blink, pend_blank, pend_dp, pend_blink;
  bit          pend_v, waiting;
  int unsigned cyc;
  logic [7:0]  exp_seg1, exp_seg2, exp_sel;
  logic        exp_fd;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        act_dig = '0; act_blank = 8'hFF; act_dp = '0; act_blink = '0;
        pend_v = 0; waiting = 1; cyc = 0;
        exp_seg1 = '0; exp_seg2 = '0; exp_sel = '0; exp_fd = 1'b0;
      end else begin
        automatic bit tk = (cyc % PHASE_LEN) == PHASE_LEN - 1;
        automatic int unsigned ph = (cyc / PHASE_LEN) % 4;
        automatic bit bl = ((cyc / BLINK_LEN) % 2) == 1;
        automatic bit bnd = tk && (ph == 3);
        exp_fd = bnd;
        exp_seg1 = '0; exp_seg2 = '0; exp_sel = '0;
        if (bus.enable && !tk && !waiting) begin
          for (int s = 0; s < 2; s++) begin
            automatic int d = (s == 0) ? 7 - ph : 3 - ph;
            automatic bit dark = act_blank[d] || (act_blink[d] && bl);
            automatic logic [7:0] g = glyph_tab[(act_dig >> (4 * d)) & 32'hF] | {7'b0, act_dp[d]};
            if (!dark) begin
              exp_sel[d] = 1'b1;
              if (s == 0) exp_seg1 = g;
              else        exp_seg2 = g;
            end
          end
        end
        if (bnd && pend_v) begin
          act_dig = pend_dig; act_blank = pend_blank; act_dp = pend_dp; act_blink = pend_blink;
        end
        if (bnd) pend_v = 0;
        if (bus.load) begin
          pend_dig = bus.digits_in; pend_blank = bus.blank_in;
          pend_dp = bus.dp_in; pend_blink = bus.blink_in; pend_v = 1;
        end
        if (!bus.enable) waiting = 1;
        else if (tk)     waiting = 0;
        cyc++;
      end
    end
  end

  // Every cycle, compare all outputs with the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check_eq("seg1", bus.seg1, exp_seg1);
      check_eq("seg2", bus.seg2, exp_seg2);
      check_eq("sel", bus.sel, exp_sel);
      check_eq("frame_done", bus.frame_done, exp_fd);
    end
  end

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < 200);
    check_eq("fd_wait", bus.frame_done, 1'b1);
  endtask

  task automatic pulse_load(input logic [31:0] d, input logic [7:0] b, input logic [7:0] p,
                            input logic [7:0] k);
    bus.digits_in = d; bus.blank_in = b; bus.dp_in = p; bus.blink_in = k;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  initial begin
    int cnt, cnt2, cnt3;
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.enable = 1'b1; bus.load = 1'b0;
    bus.digits_in = '0; bus.blank_in = '0; bus.dp_in = '0; bus.blink_in = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_sel", bus.sel, 8'h00);
    check_eq("reset_seg1", bus.seg1, 8'h00);
    reset = 1'b0;

    // Idle after reset: dark, frame_done every 4 phases.
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.sel != 0 || bus.seg1 != 0 || bus.seg2 != 0) cnt++;
    end
    check_eq("dark_idle", cnt, 0);
    wait_fd();
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.frame_done && cnt < 100);
    check_eq("fd_period", cnt, 4 * PHASE_LEN);

    // First frame appears after one boundary, with a dead cycle first.
    repeat (5) @(negedge clk);
    pulse_load(32'h1234_5678, 8'h00, 8'h00, 8'h00);
    wait_fd();
    check_eq("dead_sel", bus.sel, 8'h00);
    @(negedge clk);
    check_eq("ph0_sel", bus.sel, 8'h88);
    check_eq("ph0_seg1", bus.seg1, 8'h60);
    check_eq("ph0_seg2", bus.seg2, 8'hB6);

    // Mid-frame load does not tear; boundary-cycle load applies one frame later.
    repeat (14) @(negedge clk);
    pulse_load(32'hFFFF_FFFF, 8'h00, 8'h00, 8'h00);
    repeat (9) @(negedge clk);
    check_eq("mid_sel", bus.sel, 8'h22);
    check_eq("mid_seg1", bus.seg1, 8'hF2);
    check_eq("mid_seg2", bus.seg2, 8'hE0);
    wait_fd();
    @(negedge clk);
    check_eq("newF_seg1", bus.seg1, 8'h8E);
    check_eq("newF_seg2", bus.seg2, 8'h8E);
    repeat (38) @(negedge clk);
    pulse_load(32'h0000_0000, 8'h00, 8'h00, 8'h00);
    check_eq("bnd_fd", bus.frame_done, 1'b1);
    @(negedge clk);
    check_eq("bnd_late_seg1", bus.seg1, 8'h8E);
    wait_fd();
    @(negedge clk);
    check_eq("bnd_new_seg1", bus.seg1, 8'hFC);
    check_eq("bnd_new_seg2", bus.seg2, 8'hFC);

    // Blink on digit7, dp on digit0.
    pulse_load(32'h1234_5678, 8'h00, 8'h01, 8'h80);
    wait_fd();
    wait_fd();
    cnt = 0; cnt2 = 0; cnt3 = 0;
    repeat (400) begin
      @(negedge clk);
      if (bus.sel == 8'h08 && bus.seg1 == 8'h00) cnt++;
      if (bus.sel[7]) cnt2++;
      if (bus.sel[0] && bus.seg2 == 8'hFF) cnt3++;
    end
    check_eq("blink_dark", cnt > 0, 1'b1);
    check_eq("blink_lit", cnt2 > 0, 1'b1);
    check_eq("dp_digit0", cnt3 > 0, 1'b1);

    // Enable off/on.
    bus.enable = 1'b0;
    @(negedge clk);
    check_eq("en_off_sel", bus.sel, 8'h00);
    check_eq("en_off_seg2", bus.seg2, 8'h00);
    cnt = 0;
    repeat (4 * PHASE_LEN * 2) begin
      @(negedge clk);
      if (bus.frame_done) cnt++;
    end
    check_eq("en_off_fd", cnt, 2);
    bus.enable = 1'b1;
    repeat (60) @(negedge clk);

    // Async reset at phase 2 with a pending frame.
    wait_fd();
    repeat (3) @(negedge clk);
    pulse_load($urandom, 8'h00, 8'h00, 8'h00);
    repeat (21) @(negedge clk);
    check_eq("pre_rst_sel", bus.sel != 0, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_async_sel", bus.sel, 8'h00);
    check_eq("rst_async_seg1", bus.seg1, 8'h00);
    check_eq("rst_async_seg2", bus.seg2, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.sel != 0) cnt++;
    end
    check_eq("post_rst_dark", cnt, 0);

    // Randomized loads, masks and enable toggles.
    repeat (1500) begin
      @(negedge clk);
      bus.load = ($urandom % 30) == 0;
      if (bus.load) begin
        bus.digits_in = $urandom;
        bus.blank_in  = 8'($urandom & $urandom & $urandom);
        bus.dp_in     = 8'($urandom);
        bus.blink_in  = 8'($urandom & $urandom);
      end
      if (($urandom % 120) == 0) bus.enable = ~bus.enable;
    end
    bus.load = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
